// File: rtl/dsp_sched_pkg.sv
// Shared types for the DSP48E1 B-operand scheduler: FSM states, operand width
// and the in-flight tracker entry.
package dsp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int B_W       = 18;
  // Tracker entries reserve room for the widest supported tag; narrower tags are zero-extended.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 id;
    logic [TAG_MAX_W-1:0] tag;
  } trk_entry_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on a tie the requester that did not win the
// last accepted grant wins.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic v0,
  input  logic v1,
  input  logic update,
  output logic g0,
  output logic g1
);

  logic last_grant;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (en) begin
      if (v0 && v1) begin
        g0 = last_grant;
        g1 = ~last_grant;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
  end

  // Reset to requester 1 so requester 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= g1;
    end
  end

endmodule

// File: rtl/dsp_b_operand_scheduler.sv
// Shares one DSP48E1 B-operand path between two requesters and tracks each
// accepted operand through the slice so its id/tag reappear with the P result.
module dsp_b_operand_scheduler
  import dsp_sched_pkg::*;
#(
  parameter int BREG_p     = 2,
  parameter int PIPE_LAT_p = 3,
  parameter int TAG_W_p    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [B_W-1:0]     req0_b,
  input  logic [TAG_W_p-1:0] req0_tag,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [B_W-1:0]     req1_b,
  input  logic [TAG_W_p-1:0] req1_tag,
  input  logic               stall,
  input  logic               flush,
  output logic [B_W-1:0]     B,
  output logic               CEB1,
  output logic               CEB2,
  output logic               res_valid,
  output logic               res_id,
  output logic [TAG_W_p-1:0] res_tag,
  output logic [3:0]         inflight,
  output logic               flush_done
);

  // Total operand-to-result latency; must stay within 1..15 so inflight never wraps.
  localparam int L = BREG_p + PIPE_LAT_p;

  state_t             state;
  logic               advance;
  logic               arb_en;
  logic               g0;
  logic               g1;
  logic               accept;
  logic               win_id;
  logic [B_W-1:0]     win_b;
  logic [TAG_W_p-1:0] win_tag;
  logic [B_W-1:0]     b_hold;
  logic [3:0]         inflight_nxt;
  trk_entry_t         new_entry;
  trk_entry_t         trk_p [L];

  assign advance = ~stall;
  assign arb_en  = advance && (state != ST_FLUSH);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .v0     (req0_valid),
    .v1     (req1_valid),
    .update (accept),
    .g0     (g0),
    .g1     (g1)
  );

  assign req0_ready = g0;
  assign req1_ready = g1;
  assign accept     = g0 | g1;
  assign win_id     = g1;
  assign win_b      = win_id ? req1_b : req0_b;
  assign win_tag    = win_id ? req1_tag : req0_tag;

  // The slice samples B on the accept edge; otherwise keep the last operand on the bus.
  assign B = accept ? win_b : b_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_hold <= '0;
    end else if (accept) begin
      b_hold <= win_b;
    end
  end

  generate
    if (BREG_p == 2) begin : g_ce2
      assign CEB1 = advance;
      assign CEB2 = advance;
    end else if (BREG_p == 1) begin : g_ce1
      assign CEB1 = advance;
      assign CEB2 = 1'b0;
    end else begin : g_ce0
      assign CEB1 = 1'b0;
      assign CEB2 = 1'b0;
    end
  endgenerate

  always_comb begin
    new_entry       = '0;
    new_entry.valid = accept;
    new_entry.id    = win_id;
    new_entry.tag   = TAG_MAX_W'(win_tag);
  end

  // Tracker stage boundary: one entry per slice pipeline slot, frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        trk_p[i] <= '0;
      end
    end else if (advance) begin
      trk_p[0] <= new_entry;
      for (int i = 1; i < L; i++) begin
        trk_p[i] <= trk_p[i-1];
      end
    end
  end

  assign res_valid = trk_p[L-1].valid;
  assign res_id    = trk_p[L-1].id;
  assign res_tag   = trk_p[L-1].tag[TAG_W_p-1:0];

  always_comb begin
    inflight_nxt = inflight;
    if (advance) begin
      case ({accept, res_valid})
        2'b10:   inflight_nxt = inflight + 4'd1;
        2'b01:   inflight_nxt = inflight - 4'd1;
        default: inflight_nxt = inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 4'd0;
    end else begin
      inflight <= inflight_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (flush) begin
            state <= ST_FLUSH;
          end else if (accept) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_FLUSH;
          end else if (!accept && inflight_nxt == 4'd0) begin
            state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (inflight_nxt == 4'd0) begin
            flush_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_b_operand_scheduler.sv
// Directed bench for dsp_b_operand_scheduler: BREG=2 main instance plus BREG=1
// and BREG=0 instances sharing the stimulus for the latency/CE checks.
module tb_dsp_b_operand_scheduler;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0v = 1'b0;
  logic          r1v = 1'b0;
  logic [17:0]   r0b = '0;
  logic [17:0]   r1b = '0;
  logic [TW-1:0] r0t = '0;
  logic [TW-1:0] r1t = '0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;

  logic          rdy0, rdy1, ceb1, ceb2, rv, rid, fdone;
  logic [17:0]   b_out;
  logic [TW-1:0] rtag;
  logic [3:0]    infl;

  logic          a_rdy0, a_rdy1, a_ce1, a_ce2, a_rv, a_rid, a_fd;
  logic [17:0]   a_b;
  logic [TW-1:0] a_tag;
  logic [3:0]    a_inf;
  logic          z_rdy0, z_rdy1, z_ce1, z_ce2, z_rv, z_rid, z_fd;
  logic [17:0]   z_b;
  logic [TW-1:0] z_tag;
  logic [3:0]    z_inf;

  int checks = 0;
  int failures = 0;
  int n0, n1, g, acc, ret;
  logic          eid [6];
  logic [TW-1:0] etg [6];

  always #5 clk = ~clk;

  dsp_b_operand_scheduler #(.BREG_p(2), .PIPE_LAT_p(3), .TAG_W_p(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(rdy0), .req0_b(r0b), .req0_tag(r0t),
    .req1_valid(r1v), .req1_ready(rdy1), .req1_b(r1b), .req1_tag(r1t),
    .stall(stall), .flush(flush), .B(b_out), .CEB1(ceb1), .CEB2(ceb2),
    .res_valid(rv), .res_id(rid), .res_tag(rtag), .inflight(infl), .flush_done(fdone)
  );

  dsp_b_operand_scheduler #(.BREG_p(1), .PIPE_LAT_p(3), .TAG_W_p(TW)) dut_b1 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(a_rdy0), .req0_b(r0b), .req0_tag(r0t),
    .req1_valid(r1v), .req1_ready(a_rdy1), .req1_b(r1b), .req1_tag(r1t),
    .stall(stall), .flush(flush), .B(a_b), .CEB1(a_ce1), .CEB2(a_ce2),
    .res_valid(a_rv), .res_id(a_rid), .res_tag(a_tag), .inflight(a_inf), .flush_done(a_fd)
  );

  dsp_b_operand_scheduler #(.BREG_p(0), .PIPE_LAT_p(3), .TAG_W_p(TW)) dut_b0 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(z_rdy0), .req0_b(r0b), .req0_tag(r0t),
    .req1_valid(r1v), .req1_ready(z_rdy1), .req1_b(r1b), .req1_tag(r1t),
    .stall(stall), .flush(flush), .B(z_b), .CEB1(z_ce1), .CEB2(z_ce2),
    .res_valid(z_rv), .res_id(z_rid), .res_tag(z_tag), .inflight(z_inf), .flush_done(z_fd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step();
    step();
    #1;
    chk("rst_res_valid", 32'(rv), 32'd0);
    chk("rst_inflight", 32'(infl), 32'd0);
    chk("rst_flush_done", 32'(fdone), 32'd0);
    chk("rst_b", 32'(b_out), 32'd0);
    chk("rst_ready0", 32'(rdy0), 32'd0);
    rst = 1'b0;

    // Single operand from requester 0: BREG=2 -> L=5, BREG=1 -> 4, BREG=0 -> 3
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 0) begin
        r0v = 1'b1; r0b = 18'h000A5; r0t = 4'd3;
      end else begin
        r0v = 1'b0;
      end
      #1;
      if (k == 0) begin
        chk("t1_ready0", 32'(rdy0), 32'd1);
        chk("t1_ready1", 32'(rdy1), 32'd0);
        chk("t1_b", 32'(b_out), 32'h000A5);
        chk("t1_ceb1", 32'(ceb1), 32'd1);
        chk("t1_ceb2", 32'(ceb2), 32'd1);
        chk("t1_b1_ceb1", 32'(a_ce1), 32'd1);
        chk("t1_b1_ceb2", 32'(a_ce2), 32'd0);
        chk("t1_b0_ceb1", 32'(z_ce1), 32'd0);
        chk("t1_b0_ceb2", 32'(z_ce2), 32'd0);
      end else begin
        chk("t1_b_hold", 32'(b_out), 32'h000A5);
      end
      chk("t1_res_valid", 32'(rv), 32'(k == 5));
      chk("t1_b1_res_valid", 32'(a_rv), 32'(k == 4));
      chk("t1_b0_res_valid", 32'(z_rv), 32'(k == 3));
      chk("t1_inflight", 32'(infl), 32'((k >= 1 && k <= 5) ? 1 : 0));
      if (k == 5) begin
        chk("t1_res_id", 32'(rid), 32'd0);
        chk("t1_res_tag", 32'(rtag), 32'd3);
      end
    end

    // Reset again so the first tie of the alternation goes to requester 0
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Both requesters valid for six cycles: grants alternate 0,1,0,1,0,1
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i < 6) begin
        r0v = 1'b1; r1v = 1'b1;
        r0t = TW'(1 + n0); r1t = TW'(9 + n1);
        r0b = 18'(32'h100 + n0); r1b = 18'(32'h200 + n1);
      end else begin
        r0v = 1'b0; r1v = 1'b0;
      end
      #1;
      if (i < 6) begin
        g = i % 2;
        chk("alt_ready0", 32'(rdy0), 32'(g == 0));
        chk("alt_ready1", 32'(rdy1), 32'(g == 1));
        chk("alt_b", 32'(b_out), (g == 1) ? 32'(32'h200 + n1) : 32'(32'h100 + n0));
        eid[i] = (g == 1);
        etg[i] = (g == 1) ? TW'(9 + n1) : TW'(1 + n0);
        if (g == 1) n1++; else n0++;
      end
      if (i >= 5 && i < 11) begin
        chk("alt_res_valid", 32'(rv), 32'd1);
        chk("alt_res_id", 32'(rid), 32'(eid[i-5]));
        chk("alt_res_tag", 32'(rtag), 32'(etg[i-5]));
      end else begin
        chk("alt_res_idle", 32'(rv), 32'd0);
      end
      acc = (i < 6) ? i : 6;
      ret = (i < 5) ? 0 : ((i - 5 > 6) ? 6 : i - 5);
      chk("alt_inflight", 32'(infl), 32'(acc - ret));
    end

    // Accept at j=0, stall j=2..4 delays the result to j=8; stall at j=8 holds it
    for (int j = 0; j < 11; j++) begin
      step();
      stall = ((j >= 2 && j <= 4) || j == 8);
      if (j == 0) begin
        r0v = 1'b1; r0b = 18'h003C3; r0t = 4'd7;
      end else begin
        r0v = 1'b0;
      end
      #1;
      if (j == 0) chk("st_ready0", 32'(rdy0), 32'd1);
      chk("st_ceb1", 32'(ceb1), 32'(!stall));
      chk("st_ceb2", 32'(ceb2), 32'(!stall));
      chk("st_res_valid", 32'(rv), 32'(j == 8 || j == 9));
      chk("st_inflight", 32'(infl), 32'((j >= 1 && j <= 9) ? 1 : 0));
      if (j == 8 || j == 9) begin
        chk("st_res_id", 32'(rid), 32'd0);
        chk("st_res_tag", 32'(rtag), 32'd7);
      end
    end
    stall = 1'b0;

    // Flush while empty: one FLUSH cycle, then flush_done
    for (int e = 0; e < 4; e++) begin
      step();
      flush = (e == 0);
      #1;
      chk("fe_flush_done", 32'(fdone), 32'(e == 2));
    end

    // Three accepts, flush, drain, then a new accept is allowed
    for (int k = 0; k < 15; k++) begin
      step();
      flush = (k == 3);
      if (k < 3) begin
        r0v = 1'b1; r0t = TW'(1 + k); r0b = 18'(32'h40 + k);
      end else if (k == 3 || k >= 9) begin
        r0v = 1'b0;
      end else begin
        r0v = 1'b1; r0t = 4'd4; r0b = 18'h00044;
      end
      #1;
      if (k < 3 || k == 8) chk("fl_ready_open", 32'(rdy0), 32'd1);
      if (k >= 4 && k <= 7) chk("fl_ready_closed", 32'(rdy0), 32'd0);
      chk("fl_flush_done", 32'(fdone), 32'(k == 8));
      chk("fl_res_valid", 32'(rv), 32'(k == 5 || k == 6 || k == 7 || k == 13));
      if (k >= 5 && k <= 7) chk("fl_res_tag", 32'(rtag), 32'(k - 4));
      if (k == 13) chk("fl_res_tag_late", 32'(rtag), 32'd4);
      case (k)
        0: acc = 0;
        1: acc = 1;
        2: acc = 2;
        3, 4, 5: acc = 3;
        6: acc = 2;
        7: acc = 1;
        8, 14: acc = 0;
        default: acc = 1;
      endcase
      chk("fl_inflight", 32'(infl), 32'(acc));
    end

    // Reset with three operands in flight discards them
    for (int a = 0; a < 10; a++) begin
      step();
      rst = (a == 3);
      if (a < 3) begin
        r1v = 1'b1; r1t = TW'(5 + a); r1b = 18'(32'h300 + a);
      end else begin
        r1v = 1'b0;
      end
      #1;
      if (a < 3) chk("mr_ready1", 32'(rdy1), 32'd1);
      if (a == 3) chk("mr_inflight_before", 32'(infl), 32'd3);
      if (a == 4) begin
        chk("mr_b", 32'(b_out), 32'd0);
        chk("mr_res_id", 32'(rid), 32'd0);
        chk("mr_res_tag", 32'(rtag), 32'd0);
        chk("mr_flush_done", 32'(fdone), 32'd0);
      end
      if (a >= 4) begin
        chk("mr_res_valid", 32'(rv), 32'd0);
        chk("mr_inflight", 32'(infl), 32'd0);
      end
    end

    // First tie after reset goes to requester 0, then requester 1 is served
    step();
    r0v = 1'b1; r0t = 4'hC; r0b = 18'h00C0C;
    r1v = 1'b1; r1t = 4'hD; r1b = 18'h00D0D;
    #1;
    chk("tie_ready0", 32'(rdy0), 32'd1);
    chk("tie_ready1", 32'(rdy1), 32'd0);
    step();
    r0v = 1'b0;
    #1;
    chk("tie_next_ready1", 32'(rdy1), 32'd1);
    chk("tie_next_b", 32'(b_out), 32'h00D0D);
    step();
    r1v = 1'b0;
    for (int d = 0; d < 8; d++) step();
    #1;
    chk("end_inflight", 32'(infl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_b_operand_scheduler.md
Name: dsp_b_operand_scheduler

Overview:
Shares one DSP48E1 slice's B-operand path between two requesters.
- Round-robin arbitration with valid/ready handshake.
- Drives the slice's B data, CEB1 and CEB2, configured for the slice's BREG depth.
- Tracks every accepted operand through the fixed slice latency and returns requester id and tag when the matching P result is valid.
- Sits between the operand-producing engines and the dual B register / multiplier datapath.

Parameters:
BREG_p, 2, B pipeline depth configured in the slice (0, 1 or 2); sets which CE outputs toggle.
PIPE_LAT_p, 3, cycles from B-register output to valid P output (M + P regs etc.), 1..8.
TAG_W_p, 4, width of the per-operand tag carried alongside.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
req0_valid  in  1  requester 0 has an operand.
req0_ready  out  1  requester 0 operand accepted this cycle when valid.
req0_b  in  18  requester 0 B operand.
req0_tag  in  TAG_W_p  requester 0 tag.
req1_valid, req1_ready, req1_b, req1_tag  as requester 0, for requester 1.
stall  in  1  downstream back-pressure; freezes slice and tracker.
flush  in  1  single-cycle request: stop accepting, drain in-flight operands.
B  out  18  operand to slice B port.
CEB1  out  1  B1 register clock enable.
CEB2  out  1  B2 register clock enable.
res_valid  out  1  P output of slice holds a tracked result this cycle.
res_id  out  1  requester of that result.
res_tag  out  TAG_W_p  tag of that result.
inflight  out  4  operands accepted but not yet returned.
flush_done  out  1  one-cycle pulse: drain complete.

Behaviour:
- L = BREG_p + PIPE_LAT_p. Tracker is an L-deep shift register of {valid, id, tag}.
- advance = ~stall. All tracker shifts and counters update only on advance.
- CE outputs:
  - BREG_p=2: CEB1 = CEB2 = advance.
  - BREG_p=1: CEB1 = advance, CEB2 = 0.
  - BREG_p=0: both 0.
- Reset: state IDLE, tracker cleared, inflight 0, all outputs 0, last_grant = 1 (requester 0 wins first tie). Reset mid-operation discards all in-flight entries; no res_valid for them.
- Arbitration (combinational, only in IDLE/RUN with advance=1):
  - Single valid requester wins.
  - Both valid: the requester other than last_grant wins.
  - Only the winner sees ready=1; last_grant updates on an accept.
- Accept = valid & ready of the winner. B = winner's operand in accept cycle, else holds previous value. Requesters hold valid/b/tag stable until accepted.
- Accept at edge t (no stalls) gives res_valid at cycle t+L with that id/tag. Each stalled cycle adds exactly one cycle.
- Idle cycles with advance insert bubbles (valid=0) into the tracker.
- inflight: +1 on accept, -1 on res_valid while advancing; both at once gives no change. Saturation impossible when L <= 15; L > 15 is illegal.
- res_valid/id/tag are the tracker's last stage, registered. During stall they hold their value.
- State machine:
  - IDLE: inflight=0. Goes to RUN on accept, to FLUSH on flush.
  - RUN: goes to IDLE when inflight reaches 0 with no accept, to FLUSH on flush.
  - FLUSH: both ready=0 and flush ignored. When inflight=0, pulse flush_done for one cycle and go to IDLE.
- flush while empty: FLUSH for one cycle, then flush_done.
- flush together with an accept in the same cycle: the accept completes, then FLUSH drains it.
- flush during stall: state enters FLUSH immediately; draining waits for advance.
- stall and accept in the same cycle cannot happen (ready=0 while stalled).

Decomposition:
- Package dsp_sched_pkg: state enum (IDLE, RUN, FLUSH), B_W=18, tracker entry struct {valid, id, tag}.
- Sub-module rr_arb2: two-input round-robin arbiter with last_grant register and update enable.

Test Plan:
- Reset, then req0 only with b=18'h00A5, tag=3, at cycle 10 (BREG_p=2, PIPE_LAT_p=3) -> req0_ready=1 at cycle 10, CEB1=CEB2=1, res_valid=1 at cycle 15 with id=0, tag=3; inflight 1 during cycles 11..15, then 0.
- Both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1. Results return in the same order 5 cycles later, back-to-back.
- Accept at cycle 20, stall high during cycles 22..24 -> CEB1=CEB2=0 during the stall, res_valid delayed to cycle 28, res outputs frozen across the stall.
- Three accepts, then flush one cycle later -> readys low; flush_done pulses one cycle after the last result returns; state goes IDLE; next accept is allowed.
- Assert rst while inflight=3 -> all outputs 0 next cycle, no res_valid for the discarded entries, first tie afterwards goes to requester 0.
- BREG_p=0 and BREG_p=1 builds -> CE outputs follow the parameter table, result latency equals PIPE_LAT_p and 1+PIPE_LAT_p respectively.
